// File: rtl/save_txt_pkg.sv
// Shared types and default constants for the save_txt_gen sequence source.
package save_txt_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    COUNT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam int DATA_W_D    = 32;
  localparam int END_VAL_D   = 100;
  localparam int STEP_D      = 1;
  localparam int START_VAL_D = 0;

endpackage

// File: rtl/save_txt_gen_sat_counter.sv
// Registered saturating up-counter: loads LOAD_VAL on reset, steps by STEP while enabled,
// clamps at LIMIT. at_limit is high when the next step would reach or pass LIMIT.
module sat_counter #(
  parameter int              DATA_W   = 32,
  parameter logic [DATA_W-1:0] STEP     = 1,
  parameter logic [DATA_W-1:0] LIMIT    = 100,
  parameter logic [DATA_W-1:0] LOAD_VAL = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  output logic [DATA_W-1:0] count,
  output logic              at_limit
);

  localparam logic [DATA_W:0] STEP_X  = {1'b0, STEP};
  localparam logic [DATA_W:0] LIMIT_X = {1'b0, LIMIT};

  logic [DATA_W:0] sum;

  // One extra bit so a step past the top of the range cannot wrap below LIMIT.
  assign sum      = {1'b0, count} + STEP_X;
  assign at_limit = (sum >= LIMIT_X);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= LOAD_VAL;
    end else if (en) begin
      count <= at_limit ? LIMIT : sum[DATA_W-1:0];
    end
  end

endmodule

// File: rtl/save_txt_gen.sv
// Self-terminating monotonic sequence source: counts from START_VAL by STEP after reset,
// saturates at END_VAL and raises done until the next reset.
module save_txt_gen
  import save_txt_pkg::*;
#(
  parameter int                DATA_W    = DATA_W_D,
  parameter logic [DATA_W-1:0] START_VAL = DATA_W'(START_VAL_D),
  parameter logic [DATA_W-1:0] STEP      = DATA_W'(STEP_D),
  parameter logic [DATA_W-1:0] END_VAL   = DATA_W'(END_VAL_D)
) (
  input  logic              clk,
  input  logic              rst,
  output logic [DATA_W-1:0] dout,
  output logic              done
);

  state_t state, state_next;
  logic   count_en;
  logic   done_next;
  logic   done_reg;
  logic   hit;

  sat_counter #(
    .DATA_W  (DATA_W),
    .STEP    (STEP),
    .LIMIT   (END_VAL),
    .LOAD_VAL(START_VAL)
  ) u_counter (
    .clk     (clk),
    .rst     (rst),
    .en      (count_en),
    .count   (dout),
    .at_limit(hit)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // IDLE behaves like COUNT for one edge; it may go straight to DONE if one step reaches END_VAL.
  always_comb begin
    state_next = state;
    case (state)
      IDLE, COUNT: state_next = hit ? DONE : COUNT;
      DONE:        state_next = DONE;
      default:     state_next = IDLE;
    endcase
  end

  always_comb begin
    count_en  = 1'b0;
    done_next = 1'b0;
    case (state)
      IDLE, COUNT: begin
        count_en  = 1'b1;
        done_next = hit;
      end
      DONE: begin
        count_en  = 1'b0;
        done_next = 1'b1;
      end
      default: begin
        count_en  = 1'b0;
        done_next = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      done_reg <= 1'b0;
    end else begin
      done_reg <= done_next;
    end
  end

  assign done = done_reg;

endmodule

// File: tb/tb_save_txt_gen.sv
// Directed bench for save_txt_gen: default sequence, STEP=7 saturation, START_VAL=99 shortcut,
// and asynchronous reset mid-count and in DONE.
module tb_save_txt_gen;

  logic        clk;
  logic        rst;
  logic [31:0] dout_a, dout_b, dout_c;
  logic        done_a, done_b, done_c;

  int n_checks = 0;
  int n_errors = 0;
  int logged   = 0;

  save_txt_gen u_dut_a (
    .clk (clk),
    .rst (rst),
    .dout(dout_a),
    .done(done_a)
  );

  save_txt_gen #(.STEP(32'd7)) u_dut_b (
    .clk (clk),
    .rst (rst),
    .dout(dout_b),
    .done(done_b)
  );

  save_txt_gen #(.START_VAL(32'd99)) u_dut_c (
    .clk (clk),
    .rst (rst),
    .dout(dout_c),
    .done(done_c)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int exp_b(input int k);
    return (7 * k >= 100) ? 100 : 7 * k;
  endfunction

  task automatic check_reset_state(input string tag);
    check({tag, "_dout_a"}, dout_a, 32'd0);
    check({tag, "_done_a"}, {31'd0, done_a}, 32'd0);
    check({tag, "_dout_b"}, dout_b, 32'd0);
    check({tag, "_done_b"}, {31'd0, done_b}, 32'd0);
    check({tag, "_dout_c"}, dout_c, 32'd99);
    check({tag, "_done_c"}, {31'd0, done_c}, 32'd0);
  endtask

  initial begin
    rst = 1'b1;
    #25;
    check_reset_state("por");
    #15 rst = 1'b0;

    // Full run: edge k after release gives k until saturation at 100 on edge 100.
    for (int k = 1; k <= 103; k++) begin
      @(posedge clk);
      #1;
      if (done_a == 1'b0 && dout_a != 32'd0) logged++;
      check($sformatf("run_a_dout_%0d", k), dout_a, (k >= 100) ? 32'd100 : 32'(k));
      check($sformatf("run_a_done_%0d", k), {31'd0, done_a}, (k >= 100) ? 32'd1 : 32'd0);
      if (k <= 20) begin
        check($sformatf("step7_dout_%0d", k), dout_b, 32'(exp_b(k)));
        check($sformatf("step7_done_%0d", k), {31'd0, done_b}, (k >= 15) ? 32'd1 : 32'd0);
      end
      if (k <= 3) begin
        check($sformatf("start99_dout_%0d", k), dout_c, 32'd100);
        check($sformatf("start99_done_%0d", k), {31'd0, done_c}, 32'd1);
      end
    end
    check("logged_lines", 32'(logged), 32'd99);

    // Reset while in DONE, between edges: outputs must clear without waiting for a clock.
    #5 rst = 1'b1;
    #1;
    check_reset_state("rst_in_done");
    @(posedge clk);
    #1;
    check_reset_state("rst_held");
    #4 rst = 1'b0;

    for (int k = 1; k <= 57; k++) begin
      @(posedge clk);
      #1;
      check($sformatf("rerun_dout_%0d", k), dout_a, 32'(k));
      check($sformatf("rerun_done_%0d", k), {31'd0, done_a}, 32'd0);
    end

    // Reset mid-count at dout = 57.
    #5 rst = 1'b1;
    #1;
    check_reset_state("rst_mid");
    #6 rst = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      @(posedge clk);
      #1;
      check($sformatf("restart_dout_%0d", k), dout_a, 32'(k));
      check($sformatf("restart_done_%0d", k), {31'd0, done_a}, 32'd0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
